// File: rtl/romulus_pkg.sv
// Shared definitions for the Romulus SKINNY-128-384+ round sequencing logic:
// round count, round-constant width, sequencer state encoding and LFSR step.
package romulus_pkg;

    localparam int SKINNY_ROUNDS = 40;
    localparam int RC_WIDTH      = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROUND   = 2'd1,
        ST_CORRECT = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    // One step of the 6-bit SKINNY round-constant LFSR.
    function automatic logic [RC_WIDTH-1:0] rc_step(input logic [RC_WIDTH-1:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/skinny_rc_lfsr.sv
// Combinational UNROLL-fold round-constant LFSR: emits the constants for one
// datapath cycle (first round in the top slice) and the state after them.
module skinny_rc_lfsr
    import romulus_pkg::*;
#(
    parameter int UNROLL = 2
) (
    input  logic [RC_WIDTH-1:0]        rc_i,
    output logic [RC_WIDTH*UNROLL-1:0] constant,
    output logic [RC_WIDTH-1:0]        rc_o
);

    logic [RC_WIDTH-1:0] chain [0:UNROLL];

    assign chain[0] = rc_i;

    generate
        for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
            assign chain[gi+1] = rc_step(chain[gi]);
            assign constant[RC_WIDTH*(UNROLL-gi)-1 -: RC_WIDTH] = chain[gi+1];
        end
    endgenerate

    assign rc_o = chain[UNROLL];

endmodule

// File: rtl/tbc_round_sequencer.sv
// Cycle sequencer for one SKINNY-128-384+ TBC call: ROUNDS/UNROLL round cycles,
// one tweakey-correction cycle, then a one-cycle done pulse. Outputs are Moore.
module tbc_round_sequencer
    import romulus_pkg::*;
#(
    parameter int UNROLL = 2,
    parameter int ROUNDS = SKINNY_ROUNDS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        inc_cnt,
    output logic                        ready,
    output logic                        done,
    output logic [RC_WIDTH*UNROLL-1:0]  constant,
    output logic                        sen,
    output logic                        senc,
    output logic                        xen,
    output logic                        xenc,
    output logic                        yen,
    output logic                        yenc,
    output logic                        zen,
    output logic                        zenc,
    output logic                        correct_cnt
);

    localparam int CW     = RC_WIDTH * UNROLL;
    localparam int N_CYC  = ROUNDS / UNROLL;
    localparam int RND_W  = (N_CYC > 1) ? $clog2(N_CYC) : 1;
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(N_CYC - 1);

    generate
        if ((UNROLL < 1) || (ROUNDS % UNROLL != 0)) begin : g_bad_unroll
            $error("tbc_round_sequencer: ROUNDS must be a multiple of UNROLL");
        end
    endgenerate

    seq_state_e          state_q, state_d;
    logic [RC_WIDTH-1:0] rc_q, rc_d;
    logic [RND_W-1:0]    rnd_q, rnd_d;
    logic                inc_q, inc_d;

    logic [CW-1:0]       lfsr_constant;
    logic [RC_WIDTH-1:0] lfsr_rc_next;

    skinny_rc_lfsr #(
        .UNROLL (UNROLL)
    ) u_rc_lfsr (
        .rc_i     (rc_q),
        .constant (lfsr_constant),
        .rc_o     (lfsr_rc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
            rnd_q   <= '0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            rnd_q   <= rnd_d;
            inc_q   <= inc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        rnd_d   = rnd_q;
        inc_d   = inc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ROUND;
                    rc_d    = '0;
                    rnd_d   = '0;
                    inc_d   = inc_cnt;
                end
            end
            ST_ROUND: begin
                rc_d  = lfsr_rc_next;
                rnd_d = rnd_q + 1'b1;
                // Exact terminal compare; rnd is reloaded on the next start.
                if (rnd_q == RND_LAST) begin
                    state_d = ST_CORRECT;
                end
            end
            ST_CORRECT: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        done        = 1'b0;
        constant    = '0;
        sen         = 1'b0;
        senc        = 1'b0;
        xen         = 1'b0;
        xenc        = 1'b0;
        yen         = 1'b0;
        yenc        = 1'b0;
        zen         = 1'b0;
        zenc        = 1'b0;
        correct_cnt = 1'b0;
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_ROUND: begin
                constant = lfsr_constant;
                sen      = 1'b1;
                senc     = 1'b1;
                xen      = 1'b1;
                xenc     = 1'b1;
                yen      = 1'b1;
                yenc     = 1'b1;
                zen      = 1'b1;
                zenc     = 1'b1;
            end
            // Tweakey schedule correction: registers load their own path, not the TBC path.
            ST_CORRECT: begin
                xen         = 1'b1;
                yen         = 1'b1;
                zen         = 1'b1;
                correct_cnt = inc_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tbc_round_sequencer.sv
// Directed bench for tbc_round_sequencer (UNROLL=2 main instance, UNROLL=1 second instance).
module tb_tbc_round_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, inc_cnt = 1'b0;
    logic start1 = 1'b0, inc_cnt1 = 1'b0;

    logic        ready, done, sen, senc, xen, xenc, yen, yenc, zen, zenc, correct_cnt;
    logic [11:0] constant;
    logic        ready1, done1, sen1, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, correct_cnt1;
    logic [5:0]  constant1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tbc_round_sequencer #(.UNROLL(2), .ROUNDS(40)) dut (
        .clk(clk), .rst(rst), .start(start), .inc_cnt(inc_cnt),
        .ready(ready), .done(done), .constant(constant),
        .sen(sen), .senc(senc), .xen(xen), .xenc(xenc),
        .yen(yen), .yenc(yenc), .zen(zen), .zenc(zenc),
        .correct_cnt(correct_cnt)
    );

    tbc_round_sequencer #(.UNROLL(1), .ROUNDS(40)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .inc_cnt(inc_cnt1),
        .ready(ready1), .done(done1), .constant(constant1),
        .sen(sen1), .senc(senc1), .xen(xen1), .xenc(xenc1),
        .yen(yen1), .yenc(yenc1), .zen(zen1), .zenc(zenc1),
        .correct_cnt(correct_cnt1)
    );

    // Status order: sen senc xen xenc yen yenc zen zenc correct_cnt ready done
    localparam logic [10:0] S_IDLE  = 11'b00000000_0_1_0;
    localparam logic [10:0] S_ROUND = 11'b11111111_0_0_0;
    localparam logic [10:0] S_CORR0 = 11'b00101010_0_0_0;
    localparam logic [10:0] S_CORR1 = 11'b00101010_1_0_0;
    localparam logic [10:0] S_DONE  = 11'b00000000_0_0_1;

    function automatic logic [10:0] st0();
        return {sen, senc, xen, xenc, yen, yenc, zen, zenc, correct_cnt, ready, done};
    endfunction

    function automatic logic [10:0] st1();
        return {sen1, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, correct_cnt1, ready1, done1};
    endfunction

    function automatic logic [5:0] m_step(input logic [5:0] r);
        return {r[4:0], r[5] ^ r[4] ^ 1'b1};
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full UNROLL=2 call from IDLE. Optionally toggles start/inc_cnt during ROUND.
    task automatic run_call(input logic inc, input bit noisy);
        logic [5:0] rc_m;
        logic [5:0] a;
        logic [5:0] b;
        rc_m = 6'h00;
        start = 1'b1;
        inc_cnt = inc;
        step();
        start = 1'b0;
        inc_cnt = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            a = m_step(rc_m);
            b = m_step(a);
            rc_m = b;
            chk("round_status", c, 32'(st0()), 32'(S_ROUND));
            chk("round_const", c, 32'(constant), 32'({a, b}));
            if (c == 1)  chk("const_first", c, 32'(constant), 32'h043);
            if (c == 2)  chk("const_second", c, 32'(constant), 32'h1CF);
            if (c == 20) chk("const_last", c, 32'(constant), 32'hB5A);
            if (noisy && c < 20) begin
                start = $urandom_range(0, 1);
                inc_cnt = $urandom_range(0, 1);
            end else begin
                start = 1'b0;
                inc_cnt = 1'b0;
            end
            step();
        end
        chk("correct_status", 21, 32'(st0()), 32'(inc ? S_CORR1 : S_CORR0));
        chk("correct_const", 21, 32'(constant), 32'h0);
        step();
        chk("done_status", 22, 32'(st0()), 32'(S_DONE));
        chk("done_const", 22, 32'(constant), 32'h0);
        step();
        chk("idle_after", 23, 32'(st0()), 32'(S_IDLE));
    endtask

    initial begin
        logic [5:0] rc1;
        $display("tb_tbc_round_sequencer: start");

        // Async reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset_status", 0, 32'(st0()), 32'(S_IDLE));
        chk("reset_const", 0, 32'(constant), 32'h0);
        chk("reset_status_u1", 0, 32'(st1()), 32'(S_IDLE));
        chk("reset_const_u1", 0, 32'(constant1), 32'h0);
        #10 rst = 1'b0;
        step();
        chk("idle_hold", 0, 32'(st0()), 32'(S_IDLE));

        // Plain calls: correction with and without increment, then with noisy inputs
        run_call(1'b0, 1'b0);
        $display("call inc_cnt=0 complete");
        run_call(1'b1, 1'b0);
        $display("call inc_cnt=1 complete");
        run_call(1'b1, 1'b1);
        $display("call inc_cnt=1 with ROUND input noise complete");

        // start held high: second accept exactly 23 edges after the first
        start = 1'b1;
        step();
        chk("held_first_round", 1, 32'(st0()), 32'(S_ROUND));
        for (int c = 2; c <= 22; c++) step();
        chk("held_done", 22, 32'(st0()), 32'(S_DONE));
        step();
        chk("held_idle", 23, 32'(st0()), 32'(S_IDLE));
        step();
        start = 1'b0;
        chk("held_second_round", 24, 32'(st0()), 32'(S_ROUND));
        chk("held_second_const", 24, 32'(constant), 32'h043);
        for (int c = 25; c <= 45; c++) step();
        chk("held_second_done", 45, 32'(st0()), 32'(S_DONE));
        step();
        $display("held start spacing check complete");

        // Reset pulse during ROUND cycle 7
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 7; c++) step();
        chk("pre_abort_round", 7, 32'(st0()), 32'(S_ROUND));
        #1 rst = 1'b1;
        #1;
        chk("abort_status", 7, 32'(st0()), 32'(S_IDLE));
        chk("abort_const", 7, 32'(constant), 32'h0);
        rst = 1'b0;
        step();
        chk("abort_idle", 8, 32'(st0()), 32'(S_IDLE));
        run_call(1'b0, 1'b0);
        $display("call after mid-round reset complete");

        // UNROLL=1 instance: 40 round cycles, done at cycle 42
        rc1 = 6'h00;
        start1 = 1'b1;
        inc_cnt1 = 1'b1;
        step();
        start1 = 1'b0;
        inc_cnt1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            rc1 = m_step(rc1);
            chk("u1_round_status", c, 32'(st1()), 32'(S_ROUND));
            chk("u1_round_const", c, 32'(constant1), 32'(rc1));
            if (c == 1)  chk("u1_const_first", c, 32'(constant1), 32'h01);
            if (c == 2)  chk("u1_const_second", c, 32'(constant1), 32'h03);
            if (c == 39) chk("u1_const_penult", c, 32'(constant1), 32'h2D);
            if (c == 40) chk("u1_const_last", c, 32'(constant1), 32'h1A);
            step();
        end
        chk("u1_correct", 41, 32'(st1()), 32'(S_CORR1));
        step();
        chk("u1_done", 42, 32'(st1()), 32'(S_DONE));
        step();
        chk("u1_idle", 43, 32'(st1()), 32'(S_IDLE));
        $display("UNROLL=1 call complete");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
